// File: rtl/fetch_buffer_pkg.sv
// Shared types and constants for the instruction-fetch buffer.
package fetch_buffer_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular queue of fetched {instr, pc} pairs; clear wins over push/pop.
module fetch_fifo
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         push_i,
    input  fetch_entry_t wdata_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o
);
    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) wr_d = ptr_next(wr_q);
            if (pop_i)  rd_d = ptr_next(rd_q);
            if (push_i && !pop_i)      cnt_d = cnt_q + CW'(1);
            else if (pop_i && !push_i) cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is deliberately not reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !pop_i && !clear_i && cnt_q == CW'(DEPTH)));
endmodule

// File: rtl/fetch_buffer.sv
// Fetch buffer: issues PCs to a 1-cycle imem, queues returns, hands them to decode.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int              DEPTH = 2,
    parameter logic [XLEN-1:0] NOP   = NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] fetch_pc,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            stall,
    output logic            dec_valid,
    output logic [XLEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    input  logic            dec_ready
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic [CW-1:0]   count;
    logic [CW:0]     occupancy;
    logic            pop, push;
    fetch_entry_t    head, wentry;

    assign pop  = dec_valid & dec_ready & ~flush;
    assign push = inflight_q & ~flush;

    // Reserve a slot for the response already in flight; a same-cycle pop frees one.
    assign occupancy = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign stall     = ~flush & (occupancy >= (CW+1)'(DEPTH));
    assign imem_req  = ~stall & rst_n;
    assign imem_addr = fetch_pc;

    always_comb begin
        inflight_d    = imem_req;
        inflight_pc_d = inflight_pc_q;
        if (imem_req) inflight_pc_d = fetch_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign wentry.instr = imem_rdata;
    assign wentry.pc    = inflight_pc_q;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (flush),
        .push_i  (push),
        .wdata_i (wentry),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count)
    );

    assign dec_valid = (count != '0);
    assign dec_instr = dec_valid ? head.instr : NOP;
    assign dec_pc    = dec_valid ? head.pc    : '0;
endmodule
